// File: rtl/ex_operand_stage.sv
// Single-entry EX operand stage: holds one decoded instruction, resolves its
// operands through EX/MEM and MEM/WB forwarding, and stalls on load-use hazards.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_func,
  input  logic [6:0]      in_opcode,
  input  logic            in_alusrc,
  input  logic            in_regwrite,
  input  logic            in_memread,
  input  logic [4:0]      fwd1_rd,
  input  logic            fwd1_we,
  input  logic            fwd1_memread,
  input  logic [XLEN-1:0] fwd1_data,
  input  logic [4:0]      fwd2_rd,
  input  logic            fwd2_we,
  input  logic [XLEN-1:0] fwd2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_A,
  output logic [XLEN-1:0] out_B,
  output logic [XLEN-1:0] out_store,
  output logic [3:0]      out_func,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic [XLEN-1:0] out_pc,
  output logic [7:0]      stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  state_t          state_q, state_d, cur_state;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [3:0]      func_q;
  logic [6:0]      opcode_q;
  logic            alusrc_q, regwrite_q, memread_q;
  logic [7:0]      stall_q;

  logic            held, uses_rs2, hazard, capture;
  logic [XLEN-1:0] rs2_fwd;

  // Index 0 is hard-wired zero; a load in EX/MEM cannot forward yet, so it is skipped.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_val,
    input logic [4:0]      f1_rd,
    input logic            f1_we,
    input logic            f1_memread,
    input logic [XLEN-1:0] f1_data,
    input logic [4:0]      f2_rd,
    input logic            f2_we,
    input logic [XLEN-1:0] f2_data
  );
    if (idx == 5'd0)                             return '0;
    else if (f1_we && !f1_memread && f1_rd == idx) return f1_data;
    else if (f2_we && f2_rd == idx)                return f2_data;
    else                                           return rf_val;
  endfunction

  assign held     = (state_q != EMPTY);
  assign uses_rs2 = !alusrc_q || (opcode_q == OPC_STORE);
  assign hazard   = held && fwd1_we && fwd1_memread && (fwd1_rd != 5'd0) &&
                    ((fwd1_rd == rs1_q) || (uses_rs2 && (fwd1_rd == rs2_q)));

  // The FULL/WAIT split follows the live EX/MEM producer, so it is re-derived each cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    cur_state = EMPTY;
    state_d   = EMPTY;
    if (held) cur_state = hazard ? WAIT : FULL;
    out_valid = (cur_state == FULL);
    in_ready  = (cur_state == EMPTY) || (out_valid && out_ready);
    capture   = in_valid && in_ready && !flush;
    state_d   = cur_state;
    if (flush)                       state_d = EMPTY;
    else if (capture)                state_d = FULL;
    else if (out_valid && out_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: held datapath fields are reset too, so every out_* reads 0 during reset.
    if (!rst_n) begin
      state_q    <= EMPTY;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      func_q     <= '0;
      opcode_q   <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      if (capture) begin
        pc_q       <= in_pc;
        rs1_data_q <= in_rs1_data;
        rs2_data_q <= in_rs2_data;
        imm_q      <= in_imm;
        rs1_q      <= in_rs1;
        rs2_q      <= in_rs2;
        rd_q       <= in_rd;
        func_q     <= in_func;
        opcode_q   <= in_opcode;
        alusrc_q   <= in_alusrc;
        regwrite_q <= in_regwrite;
        memread_q  <= in_memread;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   stall_q <= 8'd0;
    else if (cur_state == WAIT && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
  end

  assign out_A = resolve(rs1_q, rs1_data_q, fwd1_rd, fwd1_we, fwd1_memread, fwd1_data,
                         fwd2_rd, fwd2_we, fwd2_data);
  assign rs2_fwd = resolve(rs2_q, rs2_data_q, fwd1_rd, fwd1_we, fwd1_memread, fwd1_data,
                           fwd2_rd, fwd2_we, fwd2_data);
  assign out_store    = rs2_fwd;
  assign out_B        = alusrc_q ? imm_q : rs2_fwd;
  assign out_func     = func_q;
  assign out_opcode   = opcode_q;
  assign out_rd       = rd_q;
  assign out_pc       = pc_q;
  assign out_regwrite = held && regwrite_q;
  assign out_memread  = held && memread_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed operand-resolution table, hand-written
// handshake/hazard/flush/reset sequences, then random traffic against a reference model.
module tb_ex_operand_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [3:0]      in_func;
  logic [6:0]      in_opcode;
  logic            in_alusrc, in_regwrite, in_memread;
  logic [4:0]      fwd1_rd, fwd2_rd;
  logic            fwd1_we, fwd1_memread, fwd2_we;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
  logic            flush, out_valid, out_ready;
  logic [XLEN-1:0] out_A, out_B, out_store, out_pc;
  logic [3:0]      out_func;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic            out_regwrite, out_memread;
  logic [7:0]      stall_count;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
    .in_opcode(in_opcode), .in_alusrc(in_alusrc), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .fwd1_rd(fwd1_rd), .fwd1_we(fwd1_we),
    .fwd1_memread(fwd1_memread), .fwd1_data(fwd1_data), .fwd2_rd(fwd2_rd),
    .fwd2_we(fwd2_we), .fwd2_data(fwd2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_A(out_A), .out_B(out_B), .out_store(out_store),
    .out_func(out_func), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_pc(out_pc),
    .stall_count(stall_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_func = 0; in_opcode = 0;
    in_alusrc = 0; in_regwrite = 0; in_memread = 0;
    fwd1_rd = 0; fwd1_we = 0; fwd1_memread = 0; fwd1_data = 0;
    fwd2_rd = 0; fwd2_we = 0; fwd2_data = 0;
    flush = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] rs1d, input logic [31:0] rs2d,
                           input logic [31:0] imm, input logic alusrc, input logic [6:0] opc,
                           input logic regwrite);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rs1_data = rs1d; in_rs2_data = rs2d;
    in_imm = imm; in_alusrc = alusrc; in_opcode = opc; in_rd = 5'd10;
    in_func = 4'b0000; in_regwrite = regwrite; in_memread = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1d, rs2d, imm;
    logic        alusrc;
    logic [6:0]  opcode;
    logic [4:0]  f1_rd;
    logic        f1_we, f1_mr;
    logic [31:0] f1_data;
    logic [4:0]  f2_rd;
    logic        f2_we;
    logic [31:0] f2_data;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_store;
  } vec_t;

  vec_t vecs[11];

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic [6:0]  opcode;
    logic        alusrc, regwrite, memread;
  } entry_t;

  entry_t      m_e;
  bit          m_full;
  int          m_stall;
  logic        uses2, haz, ev, er;
  logic [31:0] ea, eb, es;
  logic [6:0]  opcs[4];

  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (fwd1_we && !fwd1_memread && fwd1_rd == idx) return fwd1_data;
    if (fwd2_we && fwd2_rd == idx) return fwd2_data;
    return rf;
  endfunction

  initial begin
    opcs = '{7'h33, 7'h13, 7'h23, 7'h03};
    vecs[0]  = '{5'd1, 5'd2, 32'd10000, 32'd111, 32'd0, 1'b0, 7'h33, 5'd0, 1'b0, 1'b0, 32'h0,
                 5'd0, 1'b0, 32'h0, 1'b1, 32'd10000, 32'd111, 32'd111};
    vecs[1]  = '{5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 7'h33, 5'd5, 1'b1, 1'b0, 32'h0F,
                 5'd5, 1'b1, 32'h55, 1'b1, 32'h0F, 32'h22, 32'h22};
    vecs[2]  = '{5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 7'h33, 5'd5, 1'b0, 1'b0, 32'h0F,
                 5'd5, 1'b1, 32'h55, 1'b1, 32'h55, 32'h22, 32'h22};
    vecs[3]  = '{5'd0, 5'd0, 32'h1234, 32'h99, 32'd0, 1'b0, 7'h33, 5'd0, 1'b1, 1'b0, 32'hAA,
                 5'd0, 1'b1, 32'hBB, 1'b1, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{5'd4, 5'd3, 32'h44, 32'h33, 32'hFFFFFFF0, 1'b1, 7'h13, 5'd0, 1'b0, 1'b0, 32'h0,
                 5'd3, 1'b1, 32'h77, 1'b1, 32'h44, 32'hFFFFFFF0, 32'h77};
    vecs[5]  = '{5'd8, 5'd9, 32'h80, 32'h90, 32'd0, 1'b0, 7'h33, 5'd8, 1'b1, 1'b1, 32'hDEAD,
                 5'd0, 1'b0, 32'h0, 1'b0, 32'h80, 32'h90, 32'h90};
    vecs[6]  = '{5'd1, 5'd7, 32'h1, 32'h70, 32'd5, 1'b1, 7'h13, 5'd7, 1'b1, 1'b1, 32'hDEAD,
                 5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h5, 32'h70};
    vecs[7]  = '{5'd1, 5'd7, 32'h1, 32'h70, 32'd5, 1'b1, 7'h23, 5'd7, 1'b1, 1'b1, 32'hDEAD,
                 5'd0, 1'b0, 32'h0, 1'b0, 32'h1, 32'h5, 32'h70};
    vecs[8]  = '{5'd0, 5'd2, 32'h5, 32'h22, 32'd0, 1'b0, 7'h33, 5'd0, 1'b1, 1'b1, 32'hDEAD,
                 5'd0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h22, 32'h22};
    vecs[9]  = '{5'd2, 5'd3, 32'h2, 32'h3, 32'd0, 1'b0, 7'h33, 5'd4, 1'b1, 1'b1, 32'hDEAD,
                 5'd3, 1'b1, 32'h333, 1'b1, 32'h2, 32'h333, 32'h333};
    vecs[10] = '{5'd1, 5'd7, 32'h1, 32'h70, 32'd0, 1'b0, 7'h33, 5'd7, 1'b1, 1'b1, 32'hDEAD,
                 5'd7, 1'b1, 32'h777, 1'b0, 32'h1, 32'h777, 32'h777};

    // Reset state
    idle_inputs();
    rst_n = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall_count, 0);
    check("rst_out_A", out_A, 0);
    check("rst_out_B", out_B, 0);
    check("rst_out_pc", out_pc, 0);
    tick();
    rst_n = 1;

    // Operand resolution table
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      set_instr(32'h1000 + 32'(i), vecs[i].rs1, vecs[i].rs2, vecs[i].rs1d, vecs[i].rs2d,
                vecs[i].imm, vecs[i].alusrc, vecs[i].opcode, 1'b1);
      in_valid = 1;
      tick();
      in_valid = 0;
      fwd1_rd = vecs[i].f1_rd; fwd1_we = vecs[i].f1_we; fwd1_memread = vecs[i].f1_mr;
      fwd1_data = vecs[i].f1_data;
      fwd2_rd = vecs[i].f2_rd; fwd2_we = vecs[i].f2_we; fwd2_data = vecs[i].f2_data;
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_in_ready", i), in_ready, 0);
      check($sformatf("vec%0d_out_A", i), out_A, vecs[i].e_a);
      check($sformatf("vec%0d_out_B", i), out_B, vecs[i].e_b);
      check($sformatf("vec%0d_out_store", i), out_store, vecs[i].e_store);
      idle_inputs();
      out_ready = 1;
      tick();
      out_ready = 0;
    end

    // Load-use stall on rs2
    do_reset();
    set_instr(32'h100, 5'd1, 5'd7, 32'h10, 32'h70, 32'd0, 1'b0, 7'h33, 1'b1);
    in_valid = 1;
    tick();
    in_pc = 32'h200;
    fwd1_rd = 5'd7; fwd1_we = 1; fwd1_memread = 1; fwd1_data = 32'hABC;
    out_ready = 1;
    #1;
    check("lu_out_valid", out_valid, 0);
    check("lu_in_ready", in_ready, 0);
    tick();
    tick();
    check("lu_stall_2", stall_count, 2);
    check("lu_out_valid_2", out_valid, 0);
    check("lu_no_capture", out_pc, 32'h100);
    fwd1_memread = 0;
    #1;
    check("lu_release_valid", out_valid, 1);
    check("lu_release_store", out_store, 32'hABC);
    check("lu_release_ready", in_ready, 1);
    in_valid = 0;
    fwd1_we = 0;
    tick();
    check("lu_drained", out_valid, 0);

    // Backpressure then back-to-back transfers
    do_reset();
    set_instr(32'h300, 5'd1, 5'd2, 32'h11, 32'h12, 32'd0, 1'b0, 7'h33, 1'b1);
    in_valid = 1;
    tick();
    in_pc = 32'h304; in_rs1_data = 32'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp%0d_out_pc", k), out_pc, 32'h300);
      check($sformatf("bp%0d_out_A", k), out_A, 32'h11);
      tick();
    end
    out_ready = 1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    tick();
    check("b2b_valid_1", out_valid, 1);
    check("b2b_pc_1", out_pc, 32'h304);
    check("b2b_A_1", out_A, 32'h22);
    in_pc = 32'h308;
    tick();
    check("b2b_valid_2", out_valid, 1);
    check("b2b_pc_2", out_pc, 32'h308);
    in_valid = 0;
    tick();
    check("b2b_empty", out_valid, 0);

    // Flush kills held entry and blocks capture
    do_reset();
    set_instr(32'h400, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0, 1'b0, 7'h33, 1'b1);
    in_valid = 1;
    tick();
    check("fl_full_valid", out_valid, 1);
    check("fl_full_regwrite", out_regwrite, 1);
    in_pc = 32'h404;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    #1;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_regwrite", out_regwrite, 0);
    tick();
    check("fl_not_captured", out_valid, 0);

    // Asynchronous reset in WAIT
    do_reset();
    set_instr(32'h500, 5'd3, 5'd4, 32'h33, 32'h44, 32'd0, 1'b0, 7'h33, 1'b1);
    in_valid = 1;
    tick();
    in_valid = 0;
    fwd1_rd = 5'd3; fwd1_we = 1; fwd1_memread = 1;
    tick(); tick(); tick();
    check("ar_stall_3", stall_count, 3);
    #2;
    rst_n = 0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_stall", stall_count, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_out_pc", out_pc, 0);
    check("ar_out_A", out_A, 0);
    idle_inputs();
    #2;
    rst_n = 1;
    set_instr(32'h600, 5'd1, 5'd2, 32'h1, 32'h2, 32'd0, 1'b0, 7'h33, 1'b1);
    in_valid = 1;
    tick();
    check("ar_first_capture", out_valid, 1);
    check("ar_first_pc", out_pc, 32'h600);

    // Stall counter saturation
    do_reset();
    set_instr(32'h700, 5'd2, 5'd3, 32'h2, 32'h3, 32'd0, 1'b0, 7'h33, 1'b1);
    in_valid = 1;
    tick();
    in_valid = 0;
    fwd1_rd = 5'd2; fwd1_we = 1; fwd1_memread = 1;
    repeat (260) tick();
    check("sat_stall", stall_count, 255);
    check("sat_out_valid", out_valid, 0);

    // Random traffic against the reference model
    do_reset();
    m_full = 0;
    m_stall = 0;
    m_e = '{default: '0};
    for (int n = 0; n < 1500; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
      in_rd = 5'($urandom_range(0, 31)); in_func = 4'($urandom_range(0, 15));
      in_opcode = opcs[$urandom_range(0, 3)];
      in_alusrc = 1'($urandom_range(0, 1)); in_regwrite = 1'($urandom_range(0, 1));
      in_memread = 1'($urandom_range(0, 1));
      fwd1_rd = 5'($urandom_range(0, 3)); fwd1_we = 1'($urandom_range(0, 1));
      fwd1_memread = 1'($urandom_range(0, 1)); fwd1_data = $urandom;
      fwd2_rd = 5'($urandom_range(0, 3)); fwd2_we = 1'($urandom_range(0, 1));
      fwd2_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      uses2 = !m_e.alusrc || (m_e.opcode == 7'h23);
      haz = m_full && fwd1_we && fwd1_memread && (fwd1_rd != 0) &&
            ((fwd1_rd == m_e.rs1) || (uses2 && fwd1_rd == m_e.rs2));
      ev = m_full && !haz;
      er = !m_full || (ev && out_ready);
      ea = ref_operand(m_e.rs1, m_e.rs1d);
      es = ref_operand(m_e.rs2, m_e.rs2d);
      eb = m_e.alusrc ? m_e.imm : es;
      check("rnd_out_valid", out_valid, ev);
      check("rnd_in_ready", in_ready, er);
      check("rnd_out_A", out_A, ea);
      check("rnd_out_B", out_B, eb);
      check("rnd_out_store", out_store, es);
      check("rnd_out_pc", out_pc, m_e.pc);
      check("rnd_out_rd", out_rd, m_e.rd);
      check("rnd_out_func", out_func, m_e.func);
      check("rnd_out_opcode", out_opcode, m_e.opcode);
      check("rnd_out_regwrite", out_regwrite, m_full && m_e.regwrite);
      check("rnd_out_memread", out_memread, m_full && m_e.memread);
      check("rnd_stall", stall_count, m_stall);
      if (haz && m_stall < 255) m_stall++;
      if (flush) m_full = 0;
      else if (in_valid && er) begin
        m_full = 1;
        m_e.pc = in_pc; m_e.rs1d = in_rs1_data; m_e.rs2d = in_rs2_data; m_e.imm = in_imm;
        m_e.rs1 = in_rs1; m_e.rs2 = in_rs2; m_e.rd = in_rd; m_e.func = in_func;
        m_e.opcode = in_opcode; m_e.alusrc = in_alusrc; m_e.regwrite = in_regwrite;
        m_e.memread = in_memread;
      end else if (ev && out_ready) m_full = 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
